// File: rtl/reflet_timer_pkg.sv
// Shared definitions for the reflet timer: register word offsets, CTRL bit
// positions and the register-select type used by the bus decoder.
package reflet_timer_pkg;

  localparam int unsigned WORDSIZE_DEF = 16;

  localparam int unsigned timer_ctrl_off  = 0;
  localparam int unsigned timer_presc_off = 1;
  localparam int unsigned timer_cmp_off   = 2;
  localparam int unsigned timer_cnt_off   = 3;

  localparam int unsigned timer_run_bit    = 0;
  localparam int unsigned timer_reload_bit = 1;
  localparam int unsigned timer_inten_bit  = 2;
  localparam int unsigned timer_flag_bit   = 3;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'(timer_ctrl_off),
    REG_PRESC = 2'(timer_presc_off),
    REG_CMP   = 2'(timer_cmp_off),
    REG_CNT   = 2'(timer_cnt_off)
  } reg_sel_e;

endpackage

// File: rtl/reflet_timer_if.sv
// CPU-side bus of the reflet timer: access strobes, read data and match interrupt.
interface reflet_timer_if
  import reflet_timer_pkg::*;
#(
  parameter int unsigned wordsize = WORDSIZE_DEF
);

  logic                enable;
  logic [wordsize-1:0] addr;
  logic [wordsize-1:0] data_in;
  logic                write_en;
  logic [wordsize-1:0] data_out;
  logic                interrupt;

  modport master (
    output enable, addr, data_in, write_en,
    input  data_out, interrupt
  );

  modport slave (
    input  enable, addr, data_in, write_en,
    output data_out, interrupt
  );

endinterface

// File: rtl/reflet_timer_prescaler.sv
// Prescaler: counts enabled cycles 0..presc and flags the terminal cycle as a tick.
module reflet_timer_prescaler
  import reflet_timer_pkg::*;
#(
  parameter int unsigned wordsize = WORDSIZE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                count_en_i,
  input  logic                clear_i,
  input  logic [wordsize-1:0] presc_i,
  output logic                tick_c_o
);

  logic [wordsize-1:0] pcnt_q, pcnt_d;

  assign tick_c_o = count_en_i && (pcnt_q == presc_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clear_i) begin
      pcnt_d = '0;
    end else if (count_en_i) begin
      pcnt_d = tick_c_o ? '0 : pcnt_q + wordsize'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/reflet_timer.sv
// Memory-mapped timer: bus decode, CTRL/PRESCALE/COMPARE/COUNT registers,
// compare-match logic and a registered one-cycle match interrupt.
module reflet_timer
  import reflet_timer_pkg::*;
#(
  parameter int unsigned         wordsize  = WORDSIZE_DEF,
  parameter logic [wordsize-1:0] base_addr = wordsize'(16'hFF00)
) (
  input  logic           clk,
  input  logic           reset,
  reflet_timer_if.slave  bus
);

  localparam int unsigned BYTES    = wordsize / 8;
  localparam int unsigned MAP_SPAN = 4 * BYTES;

  logic                run_q, run_d, reload_q, reload_d;
  logic                inten_q, inten_d, flag_q, flag_d;
  logic [wordsize-1:0] presc_q, presc_d, cmp_q, cmp_d, cnt_q, cnt_d;
  logic [wordsize-1:0] rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic [wordsize-1:0] off;
  logic                sel;
  reg_sel_e            reg_k;
  logic                wr, ctrl_wr, presc_wr, cmp_wr, cnt_wr;
  logic                tick, match;
  logic [wordsize-1:0] ctrl_rd, reg_rd;

  // Only word-aligned addresses inside the four-register window select us.
  assign off   = bus.addr - base_addr;
  assign sel   = (off < wordsize'(MAP_SPAN)) && ((off % wordsize'(BYTES)) == '0);
  assign reg_k = reg_sel_e'(2'(off / wordsize'(BYTES)));

  assign wr       = bus.enable && bus.write_en && sel;
  assign ctrl_wr  = wr && (reg_k == REG_CTRL);
  assign presc_wr = wr && (reg_k == REG_PRESC);
  assign cmp_wr   = wr && (reg_k == REG_CMP);
  assign cnt_wr   = wr && (reg_k == REG_CNT);

  reflet_timer_prescaler #(.wordsize(wordsize)) u_presc (
    .clk        (clk),
    .reset      (reset),
    .count_en_i (bus.enable && run_q),
    .clear_i    (presc_wr || cnt_wr || ctrl_wr),
    .presc_i    (presc_q),
    .tick_c_o   (tick)
  );

  // A software COUNT write on a tick cycle suppresses match evaluation.
  assign match = tick && !cnt_wr && (cnt_q == cmp_q);

  always_comb begin
    ctrl_rd                   = '0;
    ctrl_rd[timer_run_bit]    = run_q;
    ctrl_rd[timer_reload_bit] = reload_q;
    ctrl_rd[timer_inten_bit]  = inten_q;
    ctrl_rd[timer_flag_bit]   = flag_q;
    case (reg_k)
      REG_CTRL:  reg_rd = ctrl_rd;
      REG_PRESC: reg_rd = presc_q;
      REG_CMP:   reg_rd = cmp_q;
      REG_CNT:   reg_rd = cnt_q;
    endcase
  end

  always_comb begin
    run_d    = run_q;
    reload_d = reload_q;
    inten_d  = inten_q;
    flag_d   = flag_q;
    presc_d  = presc_q;
    cmp_d    = cmp_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    irq_d    = match && inten_q;

    if (bus.enable) rdata_d = sel ? reg_rd : '0;
    if (presc_wr)   presc_d = bus.data_in;
    if (cmp_wr)     cmp_d   = bus.data_in;

    if (cnt_wr) begin
      cnt_d = bus.data_in;
    end else if (match) begin
      cnt_d = reload_q ? '0 : cnt_q;
    end else if (tick) begin
      cnt_d = cnt_q + wordsize'(1);
    end

    if (match && !reload_q) run_d = 1'b0;
    if (ctrl_wr) begin
      run_d    = bus.data_in[timer_run_bit];
      reload_d = bus.data_in[timer_reload_bit];
      inten_d  = bus.data_in[timer_inten_bit];
      if (bus.data_in[timer_flag_bit]) flag_d = 1'b0;
    end
    // Setting the flag outranks a same-cycle write-1-to-clear.
    if (match) flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q    <= 1'b0;
      reload_q <= 1'b0;
      inten_q  <= 1'b0;
      flag_q   <= 1'b0;
      presc_q  <= '0;
      cmp_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      run_q    <= run_d;
      reload_q <= reload_d;
      inten_q  <= inten_d;
      flag_q   <= flag_d;
      presc_q  <= presc_d;
      cmp_q    <= cmp_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.data_out  = rdata_q;
  assign bus.interrupt = irq_q;

endmodule

// File: doc/reflet_timer.md
Name: reflet_timer

Overview:
- Memory-mapped timer/counter peripheral on the reflet system bus, downstream of the CPU.
- Decodes CPU bus accesses (addr, data_out, write_en) to its four registers and returns read data on the CPU data_in path.
- Counts prescaled clock ticks against a compare value.
- Raises a one-cycle pulse intended for one bit of the CPU ext_int input.

Parameters:
- wordsize, 16, width of bus, registers and counters.
- base_addr, 16'hFF00, byte address of register 0. Must be aligned to 4*(wordsize/8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global enable. When 0, all state freezes and writes are ignored.
- addr  input  wordsize  bus byte address from the CPU.
- data_in  input  wordsize  write data, from the CPU data_out.
- write_en  input  1  bus write strobe.
- data_out  output  wordsize  read data to the CPU data_in. 0 when not selected, so it can be ORed with other slaves.
- interrupt  output  1  match pulse to ext_int.

Behaviour:
- Register map: register k is at base_addr + k*(wordsize/8).
  - k=0: CTRL
  - k=1: PRESCALE
  - k=2: COMPARE
  - k=3: COUNT
- Any address outside the map is unselected. Unselected addresses: no write, data_out=0 on the next cycle.
- CTRL bits:
  - [0] run
  - [1] reload: 1 = periodic, 0 = one-shot
  - [2] int_en
  - [3] flag: sticky match flag, write-1-to-clear
  - Upper bits read 0.
- CTRL writes: bits [2:0] are written directly. Bit 3 is cleared only if data_in[3]=1.
- Write timing: a write takes effect at the posedge where enable && write_en && selected.
- Read timing: data_out is registered and presents the selected register one cycle after addr. It reflects the register value before any same-cycle update.
- Prescaler:
  - pcnt counts 0..PRESCALE while run=1.
  - tick is asserted in the cycle pcnt==PRESCALE; pcnt then returns to 0.
  - PRESCALE=0 gives a tick every enabled cycle.
  - pcnt holds while run=0, and resets to 0 on any write to PRESCALE, COUNT or CTRL.run.
- Count on tick:
  - If COUNT==COMPARE, a match occurs. Otherwise COUNT <= COUNT+1, modulo 2^wordsize.
  - If COUNT>COMPARE (software-written), it wraps through all-ones to 0 and continues until it equals COMPARE.
- On match:
  - flag <= 1.
  - If reload=1: COUNT <= 0 and keep running.
  - If reload=0: COUNT holds at COMPARE and run <= 0.
- Interrupt: registered. Asserted for exactly one cycle, the cycle after the match edge, iff int_en=1 at the match. Deasserted otherwise.
- Simultaneous events:
  - Software write to COUNT in the same cycle as a tick: the write wins, no match is evaluated.
  - Flag clear in the same cycle as a match: set wins, flag=1.
  - Write setting run=0 in the same cycle as a match: run=0, and the match still takes effect (flag, interrupt).
- enable=0: all counters, registers and pcnt hold. interrupt=0. Writes are dropped. data_out holds its last value.
- Reset, at any time including mid-count: CTRL, PRESCALE, COMPARE, COUNT, pcnt, data_out and interrupt all go to 0. A pending interrupt pulse is cancelled.
- Latency: at PRESCALE=P, one count step takes P+1 cycles.
- Match-to-interrupt latency: the match evaluates at the tick edge, and interrupt is visible for the following cycle.

Decomposition:
- Shared header, the existing reflet.vh style:
  - register offset defines: timer_ctrl_off, timer_presc_off, timer_cmp_off, timer_cnt_off
  - CTRL bit index defines: timer_run_bit, timer_reload_bit, timer_inten_bit, timer_flag_bit
- One sub-module is natural: reflet_timer_prescaler.
  - Contents: pcnt, tick generation and clear input.
  - The top keeps bus decode, registers and match logic.

Test Plan:
- Reset: assert reset mid-count with COUNT=5. All reads return 0, interrupt=0. Deassert, then read CTRL -> 0 one cycle after addr.
- Periodic, PRESCALE=0, COMPARE=3, CTRL=7:
  - COUNT sequence is 0,1,2,3,0,1...
  - interrupt pulses 1 cycle every 4 cycles.
  - flag=1. Writing CTRL=8|7 clears the flag.
- One-shot, PRESCALE=2, COMPARE=2, CTRL=5:
  - match after 9 cycles; COUNT holds at 2.
  - CTRL reads 0xC: run=0, flag=1, int_en=1.
  - A single interrupt pulse.
- Wrap: write COUNT=16'hFFFE, COMPARE=1, PRESCALE=0, run=1. COUNT goes FFFE, FFFF, 0, 1, then match.
- Collisions:
  - Write COUNT=0x10 on a tick cycle: COUNT reads 0x10, no match.
  - Clear flag on the match cycle: flag reads 1.
- enable=0 for 5 cycles mid-count:
  - COUNT and pcnt are frozen, the write is ignored, interrupt=0.
  - After enable=1, counting resumes from the same value.
  - An address outside the map returns data_out=0.
